// File: rtl/core_issue_if.sv
// rtl/core_issue_if.sv - decode/execute handshake bundle for the issue controller
interface core_issue_if #(
    parameter int NREGS = 16
);
    localparam int RW = $clog2(NREGS);

    logic          in_valid;
    logic          in_ready;
    logic [RW-1:0] ra;
    logic [RW-1:0] rb;
    logic [RW-1:0] rd;
    logic          uses_ra;
    logic          uses_rb;
    logic          writeback;
    logic          is_alu;
    logic          is_mul;
    logic          is_ldst;
    logic          is_branch;
    logic          is_sys;
    logic          issue_alu;
    logic          issue_mul;
    logic          issue_ldst;
    logic          issue_branch;
    logic          issue_sys;
    logic          flush;
    logic          mul_done;
    logic          ldst_done;
    logic          mul_ack;
    logic          ldst_ack;
    logic          wb_valid;
    logic [1:0]    wb_sel;
    logic [RW-1:0] wb_rd;

    modport master (
        output in_valid, ra, rb, rd, uses_ra, uses_rb, writeback,
               is_alu, is_mul, is_ldst, is_branch, is_sys,
               flush, mul_done, ldst_done,
        input  in_ready, issue_alu, issue_mul, issue_ldst, issue_branch, issue_sys,
               mul_ack, ldst_ack, wb_valid, wb_sel, wb_rd
    );

    modport slave (
        input  in_valid, ra, rb, rd, uses_ra, uses_rb, writeback,
               is_alu, is_mul, is_ldst, is_branch, is_sys,
               flush, mul_done, ldst_done,
        output in_ready, issue_alu, issue_mul, issue_ldst, issue_branch, issue_sys,
               mul_ack, ldst_ack, wb_valid, wb_sel, wb_rd
    );
endinterface

// File: rtl/core_issue_ctrl.sv
// rtl/core_issue_ctrl.sv - in-order issue, register scoreboard and writeback port arbiter
module core_issue_ctrl #(
    parameter int NREGS = 16
) (
    input logic         clk,
    input logic         rst_n,
    core_issue_if.slave bus
);
  localparam int RW = $clog2(NREGS);

  logic [NREGS-1:0] busy, busy_next;
  logic             alu_pend;
  logic [RW-1:0]    alu_rd;
  logic             mul_busy;
  logic [RW-1:0]    mul_rd;
  logic             ldst_busy, ldst_load;
  logic [RW-1:0]    ldst_rd;

  logic hazard, unit_ok, issue;
  logic load_done, store_done, ld_win, mul_win;
  logic wb_v;
  logic [1:0]    wb_s;
  logic [RW-1:0] wb_r;

  // Done inputs only count while the unit is tracked as busy, so completions
  // that were outstanding across a reset are ignored.
  always_comb begin
    hazard = (bus.uses_ra & busy[bus.ra]) | (bus.uses_rb & busy[bus.rb]) |
             (bus.writeback & busy[bus.rd]);
    unit_ok = 1'b1;
    if (bus.is_mul)  unit_ok = !mul_busy;
    if (bus.is_ldst) unit_ok = !ldst_busy;
    if (bus.is_sys)  unit_ok = (busy == '0) && !alu_pend && !mul_busy && !ldst_busy;
    issue = rst_n & bus.in_valid & !bus.flush & !hazard & unit_ok;

    load_done  = bus.ldst_done & ldst_busy & ldst_load;
    store_done = bus.ldst_done & ldst_busy & !ldst_load;
    ld_win     = load_done & !alu_pend;
    mul_win    = bus.mul_done & mul_busy & !alu_pend & !load_done;

    wb_v = 1'b0;
    wb_s = 2'd0;
    wb_r = '0;
    if (alu_pend) begin
      wb_v = 1'b1; wb_s = 2'd1; wb_r = alu_rd;
    end else if (ld_win) begin
      wb_v = 1'b1; wb_s = 2'd3; wb_r = ldst_rd;
    end else if (mul_win) begin
      wb_v = 1'b1; wb_s = 2'd2; wb_r = mul_rd;
    end

    busy_next = busy;
    if (wb_v) busy_next[wb_r] = 1'b0;
    if (issue && bus.writeback) busy_next[bus.rd] = 1'b1;
  end

  assign bus.in_ready     = issue;
  assign bus.issue_alu    = issue & bus.is_alu;
  assign bus.issue_mul    = issue & bus.is_mul;
  assign bus.issue_ldst   = issue & bus.is_ldst;
  assign bus.issue_branch = issue & bus.is_branch;
  assign bus.issue_sys    = issue & bus.is_sys;
  assign bus.mul_ack      = mul_win;
  assign bus.ldst_ack     = ld_win | store_done;
  assign bus.wb_valid     = wb_v;
  assign bus.wb_sel       = wb_s;
  assign bus.wb_rd        = wb_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy      <= '0;
      alu_pend  <= 1'b0;
      alu_rd    <= '0;
      mul_busy  <= 1'b0;
      mul_rd    <= '0;
      ldst_busy <= 1'b0;
      ldst_load <= 1'b0;
      ldst_rd   <= '0;
    end else begin
      busy <= busy_next;
      // A link-writing branch retires through the same one-cycle path as the ALU.
      alu_pend <= issue & (bus.is_alu | bus.is_branch) & bus.writeback;
      if (issue && (bus.is_alu || bus.is_branch) && bus.writeback) alu_rd <= bus.rd;
      if (mul_win) mul_busy <= 1'b0;
      if (issue && bus.is_mul && bus.writeback) begin
        mul_busy <= 1'b1;
        mul_rd   <= bus.rd;
      end
      if (ld_win || store_done) ldst_busy <= 1'b0;
      if (issue && bus.is_ldst) begin
        ldst_busy <= 1'b1;
        ldst_load <= bus.writeback;
        ldst_rd   <= bus.rd;
      end
    end
  end
endmodule

// File: tb/tb_core_issue_ctrl.sv
// tb/tb_core_issue_ctrl.sv - directed self-checking bench for core_issue_ctrl
module tb_core_issue_ctrl;
  localparam logic [4:0] I_NO  = 5'b00000;
  localparam logic [4:0] I_ALU = 5'b10000;
  localparam logic [4:0] I_MUL = 5'b01000;
  localparam logic [4:0] I_LD  = 5'b00100;
  localparam logic [4:0] I_SYS = 5'b00001;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  core_issue_if #(.NREGS(16)) bus ();

  core_issue_ctrl #(.NREGS(16)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  logic [14:0] obs;
  assign obs = {bus.in_ready, bus.issue_alu, bus.issue_mul, bus.issue_ldst, bus.issue_branch,
                bus.issue_sys, bus.mul_ack, bus.ldst_ack, bus.wb_valid, bus.wb_sel, bus.wb_rd};

  function automatic logic [14:0] ev(input logic [4:0] iss, input logic mack, input logic lack,
                                     input logic [1:0] sel, input logic [3:0] rd);
    return {(iss != 5'b0), iss, mack, lack, (sel != 2'd0), sel, rd};
  endfunction

  task automatic chk(input string tag, input logic [14:0] exp);
    #1;
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%015b expected=%015b", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.in_valid = 0; bus.ra = 0; bus.rb = 0; bus.rd = 0;
    bus.uses_ra = 0; bus.uses_rb = 0; bus.writeback = 0;
    bus.is_alu = 0; bus.is_mul = 0; bus.is_ldst = 0; bus.is_branch = 0; bus.is_sys = 0;
    bus.flush = 0;
  endtask

  // unit: 0 alu, 1 mul, 2 ldst, 4 sys
  task automatic instr(input int unit, input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] d, input logic ua, input logic ub, input logic w);
    idle();
    bus.in_valid = 1; bus.ra = a; bus.rb = b; bus.rd = d;
    bus.uses_ra = ua; bus.uses_rb = ub; bus.writeback = w;
    bus.is_alu = (unit == 0); bus.is_mul = (unit == 1); bus.is_ldst = (unit == 2);
    bus.is_sys = (unit == 4);
  endtask

  initial begin
    idle();
    bus.mul_done = 0;
    bus.ldst_done = 0;
    instr(0, 4'd1, 4'd2, 4'd3, 1, 1, 1);
    #2;
    chk("reset_gates_issue", ev(I_NO, 0, 0, 2'd0, 4'd0));
    cyc(); cyc();
    rst_n = 1;
    idle();
    chk("reset_state", ev(I_NO, 0, 0, 2'd0, 4'd0));
    cyc();

    // dependent ALU pair
    instr(0, 4'd1, 4'd2, 4'd3, 1, 1, 1);
    chk("alu0_issue", ev(I_ALU, 0, 0, 2'd0, 4'd0));
    cyc();
    instr(0, 4'd3, 4'd1, 4'd4, 1, 1, 1);
    chk("alu1_stall_wb3", ev(I_NO, 0, 0, 2'd1, 4'd3));
    cyc();
    chk("alu1_issue_n2", ev(I_ALU, 0, 0, 2'd0, 4'd0));
    cyc();
    idle();
    chk("alu1_wb4", ev(I_NO, 0, 0, 2'd1, 4'd4));
    cyc();

    // MUL then reader
    instr(1, 4'd1, 4'd2, 4'd5, 1, 1, 1);
    chk("mul5_issue", ev(I_MUL, 0, 0, 2'd0, 4'd0));
    cyc();
    for (int i = 1; i <= 5; i++) begin
      if (i <= 3) instr(0, 4'd5, 4'd0, 4'd6, 1, 0, 1);
      else instr(1, 4'd1, 4'd2, 4'd8, 1, 1, 1);
      chk($sformatf("mul_wait_c%0d", i), ev(I_NO, 0, 0, 2'd0, 4'd0));
      cyc();
    end
    instr(1, 4'd1, 4'd2, 4'd8, 1, 1, 1);
    bus.mul_done = 1;
    chk("mul5_wb_mul2_stall", ev(I_NO, 1, 0, 2'd2, 4'd5));
    cyc();
    bus.mul_done = 0;
    instr(0, 4'd5, 4'd0, 4'd6, 1, 0, 1);
    chk("reader_issue_c7", ev(I_ALU, 0, 0, 2'd0, 4'd0));
    cyc();
    instr(1, 4'd1, 4'd2, 4'd8, 1, 1, 1);
    chk("mul8_issue_wb6", ev(I_MUL, 0, 0, 2'd1, 4'd6));
    cyc();
    idle();
    bus.mul_done = 1;
    chk("mul8_wb", ev(I_NO, 1, 0, 2'd2, 4'd8));
    cyc();
    bus.mul_done = 0;

    // triple contention
    instr(1, 4'd1, 4'd1, 4'd9, 1, 1, 1);
    chk("mul9_issue", ev(I_MUL, 0, 0, 2'd0, 4'd0));
    cyc();
    instr(2, 4'd1, 4'd0, 4'd7, 1, 0, 1);
    chk("load7_issue", ev(I_LD, 0, 0, 2'd0, 4'd0));
    cyc();
    instr(0, 4'd1, 4'd1, 4'd2, 1, 1, 1);
    chk("alu2_issue", ev(I_ALU, 0, 0, 2'd0, 4'd0));
    cyc();
    idle();
    bus.mul_done = 1;
    bus.ldst_done = 1;
    chk("contend_T_alu", ev(I_NO, 0, 0, 2'd1, 4'd2));
    cyc();
    chk("contend_T1_load", ev(I_NO, 0, 1, 2'd3, 4'd7));
    cyc();
    bus.ldst_done = 0;
    chk("contend_T2_mul", ev(I_NO, 1, 0, 2'd2, 4'd9));
    cyc();
    bus.mul_done = 0;
    chk("contend_T3_quiet", ev(I_NO, 0, 0, 2'd0, 4'd0));
    cyc();

    // store then sys
    instr(2, 4'd1, 4'd2, 4'd0, 1, 1, 0);
    chk("store_issue", ev(I_LD, 0, 0, 2'd0, 4'd0));
    cyc();
    instr(4, 4'd0, 4'd0, 4'd0, 0, 0, 0);
    chk("sys_wait0", ev(I_NO, 0, 0, 2'd0, 4'd0));
    cyc();
    chk("sys_wait1", ev(I_NO, 0, 0, 2'd0, 4'd0));
    cyc();
    bus.ldst_done = 1;
    chk("store_ack_no_wb", ev(I_NO, 0, 1, 2'd0, 4'd0));
    cyc();
    bus.ldst_done = 0;
    chk("sys_issue", ev(I_SYS, 0, 0, 2'd0, 4'd0));
    cyc();

    // flush
    instr(1, 4'd1, 4'd0, 4'd10, 1, 0, 1);
    chk("mul10_issue", ev(I_MUL, 0, 0, 2'd0, 4'd0));
    cyc();
    instr(0, 4'd1, 4'd0, 4'd11, 1, 0, 1);
    bus.flush = 1;
    chk("flush_blocks", ev(I_NO, 0, 0, 2'd0, 4'd0));
    cyc();
    instr(0, 4'd11, 4'd11, 4'd12, 1, 1, 1);
    bus.mul_done = 1;
    chk("flush_busy_clean_mul_wb", ev(I_ALU, 1, 0, 2'd2, 4'd10));
    cyc();
    bus.mul_done = 0;
    idle();
    chk("post_flush_alu_wb", ev(I_NO, 0, 0, 2'd1, 4'd12));
    cyc();

    // reset mid-operation
    instr(1, 4'd1, 4'd0, 4'd13, 1, 0, 1);
    chk("mul13_issue", ev(I_MUL, 0, 0, 2'd0, 4'd0));
    cyc();
    instr(0, 4'd1, 4'd0, 4'd14, 1, 0, 1);
    chk("alu14_issue", ev(I_ALU, 0, 0, 2'd0, 4'd0));
    cyc();
    instr(0, 4'd1, 4'd0, 4'd3, 1, 0, 1);
    bus.mul_done = 1;
    rst_n = 0;
    chk("midop_reset_zero", ev(I_NO, 0, 0, 2'd0, 4'd0));
    cyc();
    chk("midop_reset_hold", ev(I_NO, 0, 0, 2'd0, 4'd0));
    rst_n = 1;
    instr(0, 4'd13, 4'd14, 4'd15, 1, 1, 1);
    chk("post_reset_issue", ev(I_ALU, 0, 0, 2'd0, 4'd0));
    cyc();
    bus.mul_done = 0;
    idle();
    chk("post_reset_wb", ev(I_NO, 0, 0, 2'd1, 4'd15));
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/core_issue_ctrl.md
# core_issue_ctrl

In-order issue and writeback controller placed between the registered decode output and the execute units (ALU, iterative multiplier, load/store, branch). It holds each decoded instruction until its source and destination registers are free and its unit is idle, then issues it. It keeps a per-register busy scoreboard, arbitrates the single register-file write port among ALU, load and multiplier results, and serializes system/extension instructions.

## Interface
- NREGS, 16, number of architectural registers; register index width is log2(NREGS).
- clk  in  1  core clock.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  decoded instruction present.
- in_ready  out  1  instruction issued this cycle (combinational).
- ra, rb, rd  in  log2(NREGS) each  source and destination indices.
- uses_ra, uses_rb, writeback  in  1 each  operand/destination usage; already forced to 0 by decode for R0.
- is_alu, is_mul, is_ldst, is_branch, is_sys  in  1 each  unit class; at most one is high.
- issue_alu, issue_mul, issue_ldst, issue_branch, issue_sys  out  1 each  one-cycle issue strobes (combinational).
- flush  in  1  branch redirect; suppresses issue this cycle.
- mul_done  in  1  multiplier result ready; held high until mul_ack.
- ldst_done  in  1  memory op complete; held high until ldst_ack.
- mul_ack, ldst_ack  out  1 each  completion accepted (combinational).
- wb_valid  out  1  register-file write this cycle.
- wb_sel  out  2  write source: 0 none, 1 ALU, 2 MUL, 3 LDST.
- wb_rd  out  log2(NREGS)  write destination.

## Operation
- State: busy[NREGS] scoreboard; alu_pend with alu_rd; mul_busy with mul_rd; ldst_busy, ldst_load and ldst_rd.
- Issue condition, evaluated in the same cycle: in_valid & !flush & !(uses_ra & busy[ra]) & !(uses_rb & busy[rb]) & !(writeback & busy[rd]), plus the unit check.
  - Unit check: mul needs !mul_busy; ldst needs !ldst_busy; sys needs busy==0, !alu_pend, !mul_busy and !ldst_busy; alu and branch need no unit check.
  - When the condition holds: in_ready=1 and the matching issue_* strobe is high.
- On issue with writeback:
  - busy[rd] is set at the clock edge.
  - ALU: alu_pend<=1, alu_rd<=rd.
  - MUL: mul_busy<=1, mul_rd<=rd.
  - LDST load: ldst_busy<=1, ldst_load<=1, ldst_rd<=rd.
  - LDST store: ldst_busy<=1, ldst_load<=0.
- Writeback arbitration uses fixed priority: alu_pend > ldst_done (load) > mul_done.
  - The winner drives wb_valid=1 with its wb_sel and stored rd, and its busy bit clears at the edge.
  - ALU pending is cleared; the winning unit gets its ack and its busy flag clears.
  - A loser keeps its done signal asserted and is retried the next cycle.
- A store completion (ldst_done & !ldst_load) gets ldst_ack immediately, independent of the write port, with no wb_valid.
- An issue and a writeback that touch the same register in one cycle: the issue sees the pre-edge busy value, so there is no same-cycle bypass.
- A busy bit cleared and set on the same edge (new writer issued while old one retires) is impossible: WAW blocks the issue.
- flush drops only the instruction presented this cycle. In-flight ALU, MUL and LDST operations still complete and write back.
- Reset, including mid-operation:
  - Clears busy, alu_pend, mul_busy, ldst_busy and ldst_load.
  - All strobes, acks, wb_valid and in_ready read 0, wb_sel=0, wb_rd=0.
  - Outstanding completions are forgotten.

## Timing
- ALU: issue in cycle N, writeback in N+1 (always wins the port). A dependent instruction issues no earlier than N+2.
- MUL/LDST: writeback in the cycle its done is first granted. A dependent instruction issues no earlier than the next cycle.
- Port contention: when alu_pend, ldst_done and mul_done are all high, the order is ALU, then LDST one cycle later, then MUL one cycle after that.
- Sys: issues only after every pending write has retired. The next instruction may issue the following cycle.
- All issue and ack outputs are combinational from registered state and current inputs. There are no internal combinational loops through in_ready.

## Test plan
- Back-to-back dependent ALU: add r3<-r1,r2 at cycle 0, then add r4<-r3,r1.
  - Required: first issues at 0; wb_sel=1, wb_rd=3 at 1; second issues at 2 and in_ready=0 at 1.
- MUL then reader: mul r5 issued at 0, mul_done raised at 6, reader of r5 waiting.
  - Required: mul_ack and wb_sel=2, wb_rd=5 at 6; reader issues at 7; a second mul stays stalled 1..6.
- Triple contention: alu_pend (rd=2), load done (rd=7) and mul done (rd=9) in one cycle T.
  - Required: wb_rd=2 at T, 7 at T+1, 9 at T+2; acks align with these cycles.
- Store and sys serialization: store issued, then sys presented while ldst_busy.
  - Required: issue_sys stays 0 until the cycle after ldst_ack; the store ack gives no wb_valid.
- Flush: flush=1 with a hazard-free ALU instruction valid.
  - Required: no issue_alu and busy unchanged; an earlier MUL still writes back normally.
- Reset mid-op: assert rst_n=0 with alu_pend=1 and mul_busy=1.
  - Required: all outputs 0 immediately; after release, an instruction reading those registers issues on the first cycle.
